// File: rtl/wb_rr_arbiter_pkg.sv
// wb_rr_arbiter shared types and helpers.
// Arbiter FSM states and the grant-index width rule.
package wb_arb_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   // Width of a master index; never narrower than 1 bit.
   function automatic int sel_w(input int n);
      return ($clog2(n) > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Wishbone arbiter bus bundle: N master ports plus one slave port.
// Suffixes _i/_o are relative to the arbiter.
interface wb_rr_arbiter_if #(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32
);
   localparam int N  = NUM_MASTERS;
   localparam int BW = DATA_WIDTH / 8;

   logic [N-1:0]            m_cyc_i;
   logic [N-1:0]            m_stb_i;
   logic [N-1:0]            m_we_i;
   logic [N*BW-1:0]         m_sel_i;
   logic [N*ADDR_WIDTH-1:0] m_adr_i;
   logic [N*DATA_WIDTH-1:0] m_dat_i;
   logic [DATA_WIDTH-1:0]   m_dat_o;
   logic [N-1:0]            m_ack_o;
   logic [N-1:0]            m_err_o;

   logic                    s_cyc_o;
   logic                    s_stb_o;
   logic                    s_we_o;
   logic [BW-1:0]           s_sel_o;
   logic [ADDR_WIDTH-1:0]   s_adr_o;
   logic [DATA_WIDTH-1:0]   s_dat_o;
   logic [DATA_WIDTH-1:0]   s_dat_i;
   logic                    s_ack_i;
   logic                    s_err_i;

   logic [N-1:0]            grant_o;

   // Arbiter side.
   modport slave (
      input  m_cyc_i, m_stb_i, m_we_i,
      input  m_sel_i, m_adr_i, m_dat_i,
      output m_dat_o, m_ack_o, m_err_o,
      output s_cyc_o, s_stb_o, s_we_o,
      output s_sel_o, s_adr_o, s_dat_o,
      input  s_dat_i, s_ack_i, s_err_i,
      output grant_o
   );

   // Environment side: masters and the memory.
   modport master (
      output m_cyc_i, m_stb_i, m_we_i,
      output m_sel_i, m_adr_i, m_dat_i,
      input  m_dat_o, m_ack_o, m_err_o,
      input  s_cyc_o, s_stb_o, s_we_o,
      input  s_sel_o, s_adr_o, s_dat_o,
      output s_dat_i, s_ack_i, s_err_i,
      input  grant_o
   );

endinterface

// File: rtl/wb_rr_arbiter_pick.sv
// Round-robin picker: rotate past last owner, priority-encode,
// then rotate the winning position back to a master index.
module wb_rr_pick
   import wb_arb_pkg::*;
#(
   parameter int NUM_MASTERS = 2
) (
   input  logic [NUM_MASTERS-1:0]          i_req,
   input  logic [sel_w(NUM_MASTERS)-1:0]   i_last,
   output logic [sel_w(NUM_MASTERS)-1:0]   o_sel,
   output logic                            o_valid
);
   localparam int N  = NUM_MASTERS;
   localparam int SW = sel_w(N);

   logic [SW:0]    w_sh;
   logic [2*N-1:0] w_dbl;
   logic [N-1:0]   w_rot;
   logic [SW-1:0]  w_pos;
   logic [SW:0]    w_sum;

   // last+1 is at most N, so a doubled vector covers every rotation.
   assign w_sh  = {1'b0, i_last} + 1'b1;
   assign w_dbl = {i_req, i_req};
   assign w_rot = N'(w_dbl >> w_sh);

   // Lowest set bit of the rotated request wins.
   always_comb begin
      w_pos   = '0;
      o_valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_pos   = SW'(i);
            o_valid = 1'b1;
         end
      end
   end

   assign w_sum = {1'b0, w_pos} + w_sh;
   assign o_sel = (w_sum >= (SW+1)'(N))
                ? SW'(w_sum - (SW+1)'(N))
                : SW'(w_sum);

endmodule

// File: rtl/wb_rr_arbiter.sv
// Wishbone B4 classic round-robin arbiter, N masters onto one slave.
// Grants are held for a whole bus cycle; optional ack watchdog.
module wb_rr_arbiter
   import wb_arb_pkg::*;
#(
   parameter int NUM_MASTERS    = 2,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   wb_rr_arbiter_if.slave  bus
);
   localparam int N  = NUM_MASTERS;
   localparam int SW = sel_w(N);
   localparam int BW = DATA_WIDTH / 8;
   localparam int CW = (TIMEOUT_CYCLES > 0)
                     ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   arb_state_t             r_state;
   arb_state_t             w_next;
   logic [N-1:0]           r_grant;
   logic [SW-1:0]          r_last;
   logic [SW-1:0]          w_sel;
   logic                   w_valid;
   logic [N-1:0]           w_onehot;
   logic                   w_own_cyc;
   logic                   w_stall;
   logic                   w_wd_err;

   logic                   w_s_cyc;
   logic                   w_s_stb;
   logic                   w_s_we;
   logic [BW-1:0]          w_s_sel;
   logic [ADDR_WIDTH-1:0]  w_s_adr;
   logic [DATA_WIDTH-1:0]  w_s_dat;
   logic [N-1:0]           w_m_ack;
   logic [N-1:0]           w_m_err;

   wb_rr_pick #(.NUM_MASTERS(N)) u_pick (
      .i_req   (bus.m_cyc_i),
      .i_last  (r_last),
      .o_sel   (w_sel),
      .o_valid (w_valid)
   );

   // Decode the picked index into a grant vector.
   always_comb begin
      w_onehot = '0;
      for (int k = 0; k < N; k++) begin
         w_onehot[k] = (w_sel == SW'(k));
      end
   end

   assign w_own_cyc = |(r_grant & bus.m_cyc_i);

   // State register.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) r_state <= ARB_IDLE;
      else          r_state <= w_next;
   end

   // Next state: grant on any request, release when owner drops cyc.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ARB_IDLE: if (w_valid)    w_next = ARB_BUSY;
         ARB_BUSY: if (!w_own_cyc) w_next = ARB_IDLE;
         default:                  w_next = ARB_IDLE;
      endcase
   end

   // Grant and round-robin pointer.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_grant <= '0;
         r_last  <= SW'(N - 1);
      end else if (r_state == ARB_IDLE && w_valid) begin
         r_grant <= w_onehot;
         r_last  <= w_sel;
      end else if (r_state == ARB_BUSY && !w_own_cyc) begin
         r_grant <= '0;
      end
   end

   assign w_stall = (r_state == ARB_BUSY) & w_s_stb
                  & ~bus.s_ack_i & ~bus.s_err_i;

   if (TIMEOUT_CYCLES > 0) begin : g_wd
      logic [CW-1:0] r_cnt;
      logic          r_wd_err;

      // Count unterminated strobe cycles; pulse an error at the limit.
      always_ff @(posedge wb_clk_i) begin
         if (wb_rst_i) begin
            r_cnt    <= '0;
            r_wd_err <= 1'b0;
         end else begin
            r_wd_err <= 1'b0;
            if (!w_stall) begin
               r_cnt <= '0;
            end else if (r_cnt == CW'(TIMEOUT_CYCLES)) begin
               r_cnt    <= '0;
               r_wd_err <= 1'b1;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end

      assign w_wd_err = r_wd_err;
   end else begin : g_no_wd
      assign w_wd_err = 1'b0;
   end

   // Outputs: route the owner to the slave, terminations back to it.
   always_comb begin
      w_s_cyc = 1'b0;
      w_s_stb = 1'b0;
      w_s_we  = 1'b0;
      w_s_sel = '0;
      w_s_adr = '0;
      w_s_dat = '0;
      w_m_ack = '0;
      w_m_err = '0;
      if (r_state == ARB_BUSY) begin
         for (int k = 0; k < N; k++) begin
            if (r_grant[k]) begin
               w_s_cyc    = bus.m_cyc_i[k];
               w_s_stb    = bus.m_stb_i[k] & bus.m_cyc_i[k];
               w_s_we     = bus.m_we_i[k];
               w_s_sel    = bus.m_sel_i[k*BW +: BW];
               w_s_adr    = bus.m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
               w_s_dat    = bus.m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
               w_m_ack[k] = bus.s_ack_i;
               w_m_err[k] = bus.s_err_i | w_wd_err;
            end
         end
      end
   end

   assign bus.s_cyc_o = w_s_cyc;
   assign bus.s_stb_o = w_s_stb;
   assign bus.s_we_o  = w_s_we;
   assign bus.s_sel_o = w_s_sel;
   assign bus.s_adr_o = w_s_adr;
   assign bus.s_dat_o = w_s_dat;
   assign bus.m_ack_o = w_m_ack;
   assign bus.m_err_o = w_m_err;
   assign bus.m_dat_o = bus.s_dat_i;
   assign bus.grant_o = r_grant;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: N=2 reset/latency instance and
// an N=3, TIMEOUT_CYCLES=5 instance for fairness, hold, watchdog.
module tb_wb_rr_arbiter;

   logic clk;
   logic rst2;
   logic rst3;
   logic ack_en;
   logic ack_force;

   int checks = 0;
   int errors = 0;

   wb_rr_arbiter_if #(
      .NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)
   ) b2 ();

   wb_rr_arbiter_if #(
      .NUM_MASTERS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32)
   ) b3 ();

   wb_rr_arbiter #(
      .NUM_MASTERS(2), .ADDR_WIDTH(32),
      .DATA_WIDTH(32), .TIMEOUT_CYCLES(0)
   ) u2 (
      .wb_clk_i (clk),
      .wb_rst_i (rst2),
      .bus      (b2)
   );

   wb_rr_arbiter #(
      .NUM_MASTERS(3), .ADDR_WIDTH(32),
      .DATA_WIDTH(32), .TIMEOUT_CYCLES(5)
   ) u3 (
      .wb_clk_i (clk),
      .wb_rst_i (rst3),
      .bus      (b3)
   );

   // Slave model: acks a live strobe when enabled, or forced.
   assign b3.s_ack_i = ack_force | (ack_en & b3.s_stb_o);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      @(negedge clk);
   endtask

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst2 = 1'b1;
      rst3 = 1'b1;
      ack_en = 1'b0;
      ack_force = 1'b0;
      b2.m_cyc_i = '0; b2.m_stb_i = '0; b2.m_we_i = '0;
      b2.m_sel_i = '0; b2.m_adr_i = '0; b2.m_dat_i = '0;
      b2.s_dat_i = 32'h1234_5678;
      b2.s_ack_i = 1'b0; b2.s_err_i = 1'b0;
      b3.m_cyc_i = '0; b3.m_stb_i = '0; b3.m_we_i = '0;
      b3.m_sel_i = '0; b3.m_adr_i = '0; b3.m_dat_i = '0;
      b3.s_dat_i = 32'hCAFE_0001;
      b3.s_err_i = 1'b0;

      // Reset state, N=2
      step();
      step();
      look();
      chk("rst_grant", b2.grant_o, 0);
      chk("rst_s_cyc", b2.s_cyc_o, 0);
      chk("rst_s_stb", b2.s_stb_o, 0);
      chk("rst_s_adr", b2.s_adr_o, 0);
      chk("rst_m_ack", b2.m_ack_o, 0);
      chk("rst_m_err", b2.m_err_o, 0);
      chk("rst_m_dat", b2.m_dat_o, 64'h1234_5678);
      chk("rst3_grant", b3.grant_o, 0);

      // Grant latency, both masters requesting
      step();
      rst2 = 1'b0;
      rst3 = 1'b0;
      b2.m_cyc_i = 2'b11;
      b2.m_stb_i = 2'b11;
      look();
      chk("lat_grant0", b2.grant_o, 0);
      chk("lat_s_cyc0", b2.s_cyc_o, 0);
      step();
      look();
      chk("lat_grant1", b2.grant_o, 2'b01);
      chk("lat_s_cyc1", b2.s_cyc_o, 1);

      // Fairness, N=3
      ack_en = 1'b1;
      step();
      b3.m_cyc_i = 3'b111;
      b3.m_stb_i = 3'b111;
      look();
      chk("fair_idle0", b3.grant_o, 0);
      step();
      look();
      chk("fair_g0", b3.grant_o, 3'b001);
      chk("fair_ack0", b3.m_ack_o, 3'b001);
      step();
      b3.m_cyc_i = 3'b110;
      b3.m_stb_i = 3'b110;
      step();
      look();
      chk("fair_idle1", b3.grant_o, 0);
      step();
      look();
      chk("fair_g1", b3.grant_o, 3'b010);
      chk("fair_ack1", b3.m_ack_o, 3'b010);
      step();
      b3.m_cyc_i = 3'b101;
      b3.m_stb_i = 3'b101;
      step();
      look();
      chk("fair_idle2", b3.grant_o, 0);
      step();
      look();
      chk("fair_g2", b3.grant_o, 3'b100);
      chk("fair_ack2", b3.m_ack_o, 3'b100);
      step();
      b3.m_cyc_i = 3'b011;
      b3.m_stb_i = 3'b011;
      step();
      look();
      chk("fair_idle3", b3.grant_o, 0);
      step();
      look();
      chk("fair_g3", b3.grant_o, 3'b001);
      step();
      b3.m_cyc_i = 3'b000;
      b3.m_stb_i = 3'b000;
      step();

      // Grant hold: master 1 bursts 4 beats while master 0 waits
      b3.m_cyc_i = 3'b011;
      b3.m_stb_i = 3'b011;
      b3.m_adr_i[31:0] = 32'h0000_0F00;
      b3.m_adr_i[63:32] = 32'h0000_0100;
      look();
      chk("hold_idle", b3.grant_o, 0);
      step();
      for (int b = 0; b < 4; b++) begin
         b3.m_adr_i[63:32] = 32'h100 + 32'(4 * b);
         look();
         chk($sformatf("hold_ack%0d", b), b3.m_ack_o, 3'b010);
         chk($sformatf("hold_adr%0d", b), b3.s_adr_o,
             64'h100 + 64'(4 * b));
         step();
      end
      b3.m_cyc_i = 3'b001;
      b3.m_stb_i = 3'b001;
      look();
      chk("hold_drop_ack", b3.m_ack_o, 0);
      step();
      look();
      chk("hold_gap", b3.grant_o, 0);
      step();
      look();
      chk("hold_next_g", b3.grant_o, 3'b001);
      chk("hold_next_ack", b3.m_ack_o, 3'b001);
      step();
      b3.m_cyc_i = 3'b000;
      b3.m_stb_i = 3'b000;
      step();

      // Watchdog: slave never answers
      ack_en = 1'b0;
      b3.m_cyc_i = 3'b001;
      b3.m_stb_i = 3'b001;
      step();
      for (int i = 0; i < 6; i++) begin
         look();
         chk($sformatf("wd_quiet%0d", i), b3.m_err_o, 0);
         step();
      end
      look();
      chk("wd_err", b3.m_err_o, 3'b001);
      chk("wd_no_ack", b3.m_ack_o, 0);
      step();
      look();
      chk("wd_pulse_end", b3.m_err_o, 0);
      step();
      b3.m_cyc_i = 3'b000;
      b3.m_stb_i = 3'b000;
      step();

      // Watchdog: ack lands on the limit cycle
      b3.m_cyc_i = 3'b001;
      b3.m_stb_i = 3'b001;
      step();
      repeat (5) step();
      ack_force = 1'b1;
      look();
      chk("wdl_ack", b3.m_ack_o, 3'b001);
      chk("wdl_err_now", b3.m_err_o, 0);
      step();
      ack_force = 1'b0;
      look();
      chk("wdl_err_next", b3.m_err_o, 0);
      step();
      b3.m_cyc_i = 3'b000;
      b3.m_stb_i = 3'b000;
      step();

      // Write path from master 1
      b3.m_we_i  = 3'b010;
      b3.m_sel_i = {4'hC, 4'h3, 4'hF};
      b3.m_adr_i = {32'h0000_3000, 32'h0000_2000, 32'hAAAA_0000};
      b3.m_dat_i = {32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};
      b3.m_cyc_i = 3'b010;
      b3.m_stb_i = 3'b010;
      look();
      chk("wr_latency", b3.s_cyc_o, 0);
      step();
      look();
      chk("wr_dat", b3.s_dat_o, 64'hDEAD_BEEF);
      chk("wr_sel", b3.s_sel_o, 4'h3);
      chk("wr_adr", b3.s_adr_o, 64'h2000);
      chk("wr_we", b3.s_we_o, 1);
      chk("wr_stb", b3.s_stb_o, 1);

      // Reset in the middle of the cycle, slave acks afterwards
      rst3 = 1'b1;
      step();
      ack_force = 1'b1;
      look();
      chk("mrst_grant", b3.grant_o, 0);
      chk("mrst_ack", b3.m_ack_o, 0);
      chk("mrst_s_cyc", b3.s_cyc_o, 0);
      chk("mrst_m_dat", b3.m_dat_o, 64'hCAFE_0001);
      step();
      rst3 = 1'b0;
      look();
      chk("mrst_ack_after", b3.m_ack_o, 0);
      step();
      ack_force = 1'b0;
      b3.m_cyc_i = 3'b000;
      b3.m_stb_i = 3'b000;
      step();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Parametrised Wishbone B4 classic arbiter that merges `NUM_MASTERS` master ports onto one slave port. Grants are round-robin and held for a whole bus cycle, and an optional ack watchdog terminates stalled cycles with an error. It sits between a core's instruction and data ports (or several cores) and a single memory/controller port, replacing fixed two-port wiring when only one memory is available.

## Interface
Parameters:
- `NUM_MASTERS`, 2: number of master ports; must be at least 1.
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width; must be a multiple of 8.
- `TIMEOUT_CYCLES`, 255: watchdog limit in cycles; 0 disables the watchdog.

Ports:
- `wb_clk_i`  in  1  single clock; all logic on the rising edge.
- `wb_rst_i`  in  1  reset, synchronous, active-high.
- `m_cyc_i`  in  N  per-master cycle.
- `m_stb_i`  in  N  per-master strobe.
- `m_we_i`  in  N  per-master write enable.
- `m_sel_i`  in  N*DATA_WIDTH/8  byte selects; master k occupies slice k.
- `m_adr_i`  in  N*ADDR_WIDTH  addresses; master k occupies slice k.
- `m_dat_i`  in  N*DATA_WIDTH  write data; master k occupies slice k.
- `m_dat_o`  out  DATA_WIDTH  read data, broadcast to all masters.
- `m_ack_o`  out  N  per-master ack.
- `m_err_o`  out  N  per-master error.
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1  slave control.
- `s_sel_o`  out  DATA_WIDTH/8  slave byte selects.
- `s_adr_o`  out  ADDR_WIDTH  slave address.
- `s_dat_o`  out  DATA_WIDTH  slave write data.
- `s_dat_i`  in  DATA_WIDTH  slave read data.
- `s_ack_i`, `s_err_i`  in  1  slave termination.
- `grant_o`  out  N  one-hot current grant; all zero when idle.

## Operation
- FSM has two states.
- IDLE:
  - All `s_*` outputs are 0.
  - If any `m_cyc_i` is set, the picker selects the first requester in order `last+1, last+2, …` (mod N).
  - On the next edge: `grant <= onehot(sel)`, `last <= sel`, move to BUSY.
- BUSY:
  - `s_cyc_o = m_cyc_i[g]`, `s_stb_o = m_stb_i[g] & m_cyc_i[g]`.
  - `s_we_o`, `s_sel_o`, `s_adr_o` and `s_dat_o` are muxed from master g, combinationally.
  - `m_ack_o[g] = s_ack_i`, `m_err_o[g] = s_err_i | wd_err`. Ack and err for every other master are 0.
  - `m_dat_o = s_dat_i` at all times.
- Grant hold: the grant stays with master g while `m_cyc_i[g]` is high, so multi-beat and RMW cycles are not split.
  - When `m_cyc_i[g]` is low at an edge: `grant <= 0`, return to IDLE.
  - A new grant is issued on the following edge, so there is at least one idle cycle between owners.
- Watchdog (when `TIMEOUT_CYCLES > 0`):
  - The counter increments each BUSY cycle in which `s_stb_o` is 1 and both `s_ack_i` and `s_err_i` are 0.
  - It clears on ack, on err, on `s_stb_o` = 0, and in IDLE.
  - When the count equals `TIMEOUT_CYCLES`, `wd_err` is a registered 1-cycle pulse to master g and the counter clears.
  - The slave is not signalled; the master is required to drop `stb`/`cyc`.
- Counter width is `$clog2(TIMEOUT_CYCLES+1)`, and it never wraps past the limit.
- Simultaneous events:
  - Ack in the same cycle as the timeout: the ack wins and no `wd_err` is raised.
  - Grantee drops `cyc` while another master requests: IDLE for one cycle, then the other master is granted.
- Reset:
  - `grant = 0`, state = IDLE, counter = 0, `last = N-1` (master 0 has first priority).
  - Every output reads 0, except `m_dat_o`, which follows `s_dat_i`.
  - Reset in the middle of a cycle aborts it at that edge; no ack or err is forwarded afterwards.

## Timing
- Grant latency: 1 cycle from `m_cyc_i` rising in IDLE to `s_cyc_o` = 1.
- Data path, once granted: 0 cycles in both directions; muxes only, no registering of address, data or ack.
- Handover: a minimum of 1 idle cycle between consecutive owners.
- Watchdog error: `m_err_o` rises `TIMEOUT_CYCLES` + 1 edges after the first unacked strobe cycle.
- With N=1 the arbiter still inserts the 1-cycle grant latency.

## Structure
- Package `wb_arb_pkg`: `arb_state_t` enum {ARB_IDLE, ARB_BUSY} and a `sel_w(n)` function returning `max(1, $clog2(n))`.
- Sub-module `wb_rr_pick` (combinational):
  - Inputs: request vector and `last`.
  - Outputs: `sel` index and `valid`.
  - Implemented as a rotate, a priority encoder and an un-rotate.
- Top level holds the FSM, grant/last registers, watchdog counter and output muxes.

## Test plan
- Reset with N=2: every output is 0 and `grant_o` = 00. Raise `m_cyc_i` = 11 → after 1 cycle `grant_o` = 01.
- Fairness, N=3, all masters requesting, slave acks each single-beat cycle: grants cycle 001 → 010 → 100 → 001, with one IDLE cycle between each.
- Grant hold: master 1 keeps `cyc` high for 4 beats at addr 0x100..0x10C while master 0 requests. All 4 acks go to master 1 only; master 0 is granted afterwards.
- Watchdog, `TIMEOUT_CYCLES` = 5, slave never acks: `m_err_o[g]` pulses 1 cycle, 6 edges after the first strobe cycle, and `m_ack_o` stays 0. Ack arriving on the limit cycle → ack delivered, no err.
- Write path: master 1 writes 0xDEADBEEF, sel 0x3, addr 0x2000 → `s_dat_o`, `s_sel_o`, `s_adr_o` and `s_we_o` match combinationally during the grant.
- Reset asserted mid-BUSY with the slave acking next cycle: grant clears at the reset edge and no `m_ack_o` is asserted afterwards.
